// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, special instruction encodings and the IF/ID bundle shared by the fetch stage.
package fetch_pkg;
   localparam int PC_W = 16;
   localparam int INSTR_W = 16;
   localparam logic [INSTR_W-1:0] NOP = 16'h0000;
   localparam logic [INSTR_W-1:0] HALT = 16'hF000;
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0] pc_next;
      logic valid;
   } ifid_t;
   localparam ifid_t BUBBLE = '{instr: NOP, pc_next: '0, valid: 1'b0};
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory read bus; master is the fetch stage, slave is the memory.
interface fetch_if;
   logic [fetch_pkg::PC_W-1:0] imem_addr;
   logic [fetch_pkg::INSTR_W-1:0] imem_instr;
   modport master(output imem_addr, input imem_instr);
   modport slave(input imem_addr, output imem_instr);
endinterface

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with hold and bubble-load; bubble wins over hold.
module ifid_reg
   import fetch_pkg::*;
(
   input logic clk,
   input logic rst,
   input logic hold,
   input logic bubble,
   input ifid_t d,
   output ifid_t q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= BUBBLE;
      else if (bubble) q <= BUBBLE;
      else if (!hold) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register driving instruction memory, captured into IF/ID one cycle later.
// Define FETCH_HALT_EN to freeze fetch once a HALT instruction is captured.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter logic [PC_W-1:0] PC_STEP = 16'd2
) (
   input logic clk,
   input logic rst,
   input logic stall,
   input logic flush,
   input logic redirect_valid,
   input logic [PC_W-1:0] redirect_pc,
   fetch_if.master imem,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0] ifid_pc_next,
   output logic ifid_valid,
   output logic halted
);
   logic [PC_W-1:0] pc, pc_inc, pc_d;
   logic unused_bit;
   ifid_t ifid_d, ifid_q;
   assign unused_bit = redirect_pc[0];
   assign imem.imem_addr = pc;
   assign pc_inc = pc + PC_STEP;
   always_comb begin
      pc_d = redirect_valid ? {redirect_pc[PC_W-1:1], 1'b0} : (stall || halted) ? pc : pc_inc;
      ifid_d = '{instr: imem.imem_instr, pc_next: pc_inc, valid: 1'b1};
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) pc <= RESET_PC;
      else pc <= pc_d;
`ifdef FETCH_HALT_EN
   // halted rises on the same edge that captures HALT into IF/ID
   always_ff @(posedge clk or posedge rst)
      if (rst) halted <= 1'b0;
      else if (redirect_valid) halted <= 1'b0;
      else if (!stall && !flush && !halted && imem.imem_instr == HALT) halted <= 1'b1;
`else
   assign halted = 1'b0;
`endif
   ifid_reg u_ifid (
      .clk(clk),
      .rst(rst),
      .hold(stall),
      .bubble(redirect_valid || flush || halted),
      .d(ifid_d),
      .q(ifid_q)
   );
   assign ifid_instr = ifid_q.instr;
   assign ifid_pc_next = ifid_q.pc_next;
   assign ifid_valid = ifid_q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus halt and async-reset sequences, checked through a scoreboard queue.
module tb_fetch_stage;
   typedef struct {
      logic [2:0] ctl;
      logic [15:0] rpc;
      logic [15:0] addr;
      logic [15:0] instr;
      logic [15:0] pcn;
      logic valid;
      logic halted;
   } vec_t;

   logic clk = 1'b0;
   logic rst, stall, flush, redirect_valid;
   logic [15:0] redirect_pc, ifid_instr, ifid_pc_next;
   logic ifid_valid, halted;
   int checks = 0;
   int failures = 0;
   vec_t sb[$];
   vec_t tbl[18];

   fetch_if bus();

   fetch_stage dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .flush(flush),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem(bus),
      .ifid_instr(ifid_instr),
      .ifid_pc_next(ifid_pc_next),
      .ifid_valid(ifid_valid),
      .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] imem(input logic [15:0] a);
      return a == 16'h0000 ? 16'h4010 : a == 16'h0002 ? 16'h5230 :
             a == 16'h0008 ? 16'hF000 : a ^ 16'h1234;
   endfunction

   always_comb bus.imem_instr = imem(bus.imem_addr);

   function automatic vec_t mk(input logic [2:0] c, input logic [15:0] r, input logic [15:0] a,
                               input logic [15:0] i, input logic [15:0] p, input logic v, input logic h);
      vec_t t;
      t.ctl = c; t.rpc = r; t.addr = a; t.instr = i; t.pcn = p; t.valid = v; t.halted = h;
      return t;
   endfunction

   task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      cmp({tag, " addr"}, bus.imem_addr, 16'h0000);
      cmp({tag, " instr"}, ifid_instr, 16'h0000);
      cmp({tag, " pc_next"}, ifid_pc_next, 16'h0000);
      cmp({tag, " valid"}, {15'd0, ifid_valid}, 16'h0000);
      cmp({tag, " halted"}, {15'd0, halted}, 16'h0000);
   endtask

   // called just after a falling edge; returns just after the next falling edge
   task automatic apply(input string tag, input vec_t v);
      vec_t e;
      {stall, flush, redirect_valid} = v.ctl;
      redirect_pc = v.rpc;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp({tag, " addr"}, bus.imem_addr, e.addr);
      cmp({tag, " instr"}, ifid_instr, e.instr);
      cmp({tag, " pc_next"}, ifid_pc_next, e.pcn);
      cmp({tag, " valid"}, {15'd0, ifid_valid}, {15'd0, e.valid});
      cmp({tag, " halted"}, {15'd0, halted}, {15'd0, e.halted});
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
      #1;
      chk_reset("reset");
      tbl[0]  = mk(3'b000, 16'h0000, 16'h0002, 16'h4010, 16'h0002, 1'b1, 1'b0);
      tbl[1]  = mk(3'b000, 16'h0000, 16'h0004, 16'h5230, 16'h0004, 1'b1, 1'b0);
      tbl[2]  = mk(3'b100, 16'h0000, 16'h0004, 16'h5230, 16'h0004, 1'b1, 1'b0);
      tbl[3]  = mk(3'b100, 16'h0000, 16'h0004, 16'h5230, 16'h0004, 1'b1, 1'b0);
      tbl[4]  = mk(3'b100, 16'h0000, 16'h0004, 16'h5230, 16'h0004, 1'b1, 1'b0);
      tbl[5]  = mk(3'b000, 16'h0000, 16'h0006, imem(16'h0004), 16'h0006, 1'b1, 1'b0);
      tbl[6]  = mk(3'b101, 16'h0021, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tbl[7]  = mk(3'b000, 16'h0000, 16'h0022, imem(16'h0020), 16'h0022, 1'b1, 1'b0);
      tbl[8]  = mk(3'b010, 16'h0000, 16'h0024, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tbl[9]  = mk(3'b000, 16'h0000, 16'h0026, imem(16'h0024), 16'h0026, 1'b1, 1'b0);
      tbl[10] = mk(3'b110, 16'h0000, 16'h0026, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tbl[11] = mk(3'b100, 16'h0000, 16'h0026, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tbl[12] = mk(3'b000, 16'h0000, 16'h0028, imem(16'h0026), 16'h0028, 1'b1, 1'b0);
      tbl[13] = mk(3'b001, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tbl[14] = mk(3'b000, 16'h0000, 16'h0000, imem(16'hFFFE), 16'h0000, 1'b1, 1'b0);
      tbl[15] = mk(3'b001, 16'h0007, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tbl[16] = mk(3'b011, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tbl[17] = mk(3'b000, 16'h0000, 16'h0102, imem(16'h0100), 16'h0102, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 18; i++) apply($sformatf("vec%0d", i), tbl[i]);
      apply("halt redirect8", mk(3'b001, 16'h0008, 16'h0008, 16'h0000, 16'h0000, 1'b0, 1'b0));
`ifdef FETCH_HALT_EN
      apply("halt capture", mk(3'b000, 16'h0000, 16'h000A, 16'hF000, 16'h000A, 1'b1, 1'b1));
      apply("halt hold1", mk(3'b000, 16'h0000, 16'h000A, 16'h0000, 16'h0000, 1'b0, 1'b1));
      apply("halt hold2", mk(3'b000, 16'h0000, 16'h000A, 16'h0000, 16'h0000, 1'b0, 1'b1));
`else
      apply("halt plain", mk(3'b000, 16'h0000, 16'h000A, 16'hF000, 16'h000A, 1'b1, 1'b0));
      apply("halt next1", mk(3'b000, 16'h0000, 16'h000C, imem(16'h000A), 16'h000C, 1'b1, 1'b0));
      apply("halt next2", mk(3'b000, 16'h0000, 16'h000E, imem(16'h000C), 16'h000E, 1'b1, 1'b0));
`endif
      apply("halt redirect0", mk(3'b001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
      apply("halt resume", mk(3'b000, 16'h0000, 16'h0002, 16'h4010, 16'h0002, 1'b1, 1'b0));
      #2;
      rst = 1'b1;
      #1;
      chk_reset("async rst");
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
      @(posedge clk);
      #1;
      chk_reset("rst held");
      @(negedge clk);
      rst = 1'b0;
      apply("post rst", mk(3'b000, 16'h0000, 16'h0002, 16'h4010, 16'h0002, 1'b1, 1'b0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
